// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: 2:1 AXI3 arbiter (icache M0, dcache M1) onto one slave port.
// Read and write sides arbitrate independently, one transaction in flight each.
module axi_master_arbiter #(
    parameter logic [3:0] M0_ID = 4'd0,
    parameter logic [3:0] M1_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    input  logic [1:0]  m0_arlock,
    input  logic [3:0]  m0_arcache,
    input  logic [2:0]  m0_arprot,
    input  logic        m0_arvalid,
    input  logic [3:0]  m0_arid,
    output logic        m0_arready,
    output logic [3:0]  m0_rid,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rlast,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [3:0]  m0_awid,
    input  logic [31:0] m0_awaddr,
    input  logic [7:0]  m0_awlen,
    input  logic [2:0]  m0_awsize,
    input  logic [1:0]  m0_awburst,
    input  logic [1:0]  m0_awlock,
    input  logic [3:0]  m0_awcache,
    input  logic [2:0]  m0_awprot,
    input  logic        m0_awvalid,
    output logic        m0_awready,
    input  logic [3:0]  m0_wid,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_wlast,
    input  logic        m0_wvalid,
    output logic        m0_wready,
    output logic [3:0]  m0_bid,
    output logic [1:0]  m0_bresp,
    output logic        m0_bvalid,
    input  logic        m0_bready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    input  logic [1:0]  m1_arlock,
    input  logic [3:0]  m1_arcache,
    input  logic [2:0]  m1_arprot,
    input  logic        m1_arvalid,
    input  logic [3:0]  m1_arid,
    output logic        m1_arready,
    output logic [3:0]  m1_rid,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rlast,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    input  logic [3:0]  m1_awid,
    input  logic [31:0] m1_awaddr,
    input  logic [7:0]  m1_awlen,
    input  logic [2:0]  m1_awsize,
    input  logic [1:0]  m1_awburst,
    input  logic [1:0]  m1_awlock,
    input  logic [3:0]  m1_awcache,
    input  logic [2:0]  m1_awprot,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [3:0]  m1_wid,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wlast,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic [3:0]  m1_bid,
    output logic [1:0]  m1_bresp,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    output logic [3:0]  s_arid,
    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    output logic [1:0]  s_arlock,
    output logic [3:0]  s_arcache,
    output logic [2:0]  s_arprot,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [3:0]  s_rid,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [3:0]  s_awid,
    output logic [31:0] s_awaddr,
    output logic [7:0]  s_awlen,
    output logic [2:0]  s_awsize,
    output logic [1:0]  s_awburst,
    output logic [1:0]  s_awlock,
    output logic [3:0]  s_awcache,
    output logic [2:0]  s_awprot,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [3:0]  s_wid,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wlast,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [3:0]  s_bid,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);
    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_B} wr_state_t;

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;
    logic rd_gnt, rd_last, wr_gnt, wr_last, aw_done, w_done;
    logic rd_start, rd_pick, ar_act, r_act, ar_hs, r_end;
    logic wr_start, wr_pick, aw_act, b_act, aw_fwd, w_fwd, aw_hs, wl_hs, wr_exit, b_route, b_hs;
    logic unused_ids;

    // Master-side IDs are replaced by the fixed per-master IDs
    assign unused_ids = ^{m0_arid, m1_arid, m0_awid, m1_awid, m0_wid, m1_wid};

    assign rd_start = (rd_state == RD_IDLE) && (m0_arvalid || m1_arvalid);
    assign rd_pick  = (m0_arvalid && m1_arvalid) ? ~rd_last : m1_arvalid;
    assign ar_act   = rd_state == RD_AR;
    assign r_act    = rd_state == RD_R;
    assign ar_hs    = ar_act && (rd_gnt ? m1_arvalid : m0_arvalid) && s_arready;
    assign r_end    = r_act && s_rvalid && (rd_gnt ? m1_rready : m0_rready) && s_rlast;

    assign wr_start = (wr_state == WR_IDLE) && (m0_awvalid || m1_awvalid);
    assign wr_pick  = (m0_awvalid && m1_awvalid) ? ~wr_last : m1_awvalid;
    assign aw_act   = wr_state == WR_AW;
    assign b_act    = wr_state == WR_B;
    assign aw_fwd   = aw_act && !aw_done;
    assign w_fwd    = aw_act && !w_done;
    assign aw_hs    = aw_fwd && (wr_gnt ? m1_awvalid : m0_awvalid) && s_awready;
    assign wl_hs    = w_fwd && (wr_gnt ? m1_wvalid && m1_wlast : m0_wvalid && m0_wlast) && s_wready;
    assign wr_exit  = aw_act && (aw_done || aw_hs) && (w_done || wl_hs);
    // A response landing in the AW/W completion cycle is already routed to the grant
    assign b_route  = b_act || wr_exit;
    assign b_hs     = b_route && s_bvalid && (wr_gnt ? m1_bready : m0_bready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= RD_IDLE;
            rd_gnt   <= 1'b0;
            rd_last  <= 1'b1;
        end else begin
            rd_state <= rd_next;
            if (rd_start) rd_gnt <= rd_pick;
            if (ar_hs) rd_last <= rd_gnt;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (rd_start) rd_next = RD_AR;
            RD_AR:   if (ar_hs) rd_next = RD_R;
            RD_R:    if (r_end) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        {s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot} = !ar_act ? '0 :
            rd_gnt ? {m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arlock, m1_arcache, m1_arprot}
                   : {m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arlock, m0_arcache, m0_arprot};
        s_arid     = !ar_act ? 4'd0 : rd_gnt ? M1_ID : M0_ID;
        s_arvalid  = ar_act && (rd_gnt ? m1_arvalid : m0_arvalid);
        m0_arready = ar_act && !rd_gnt && s_arready;
        m1_arready = ar_act && rd_gnt && s_arready;
        {m0_rid, m0_rdata, m0_rresp, m0_rlast} = (r_act && !rd_gnt) ? {s_rid, s_rdata, s_rresp, s_rlast} : '0;
        {m1_rid, m1_rdata, m1_rresp, m1_rlast} = (r_act && rd_gnt) ? {s_rid, s_rdata, s_rresp, s_rlast} : '0;
        m0_rvalid  = r_act && !rd_gnt && s_rvalid;
        m1_rvalid  = r_act && rd_gnt && s_rvalid;
        s_rready   = r_act && (rd_gnt ? m1_rready : m0_rready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state <= WR_IDLE;
            wr_gnt   <= 1'b0;
            wr_last  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            if (wr_start) begin
                wr_gnt  <= wr_pick;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (wl_hs) w_done <= 1'b1;
            end
            if (b_hs) wr_last <= wr_gnt;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (wr_start) wr_next = WR_AW;
            WR_AW:   if (wr_exit) wr_next = b_hs ? WR_IDLE : WR_B;
            WR_B:    if (b_hs) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        {s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot} = !aw_fwd ? '0 :
            wr_gnt ? {m1_awaddr, m1_awlen, m1_awsize, m1_awburst, m1_awlock, m1_awcache, m1_awprot}
                   : {m0_awaddr, m0_awlen, m0_awsize, m0_awburst, m0_awlock, m0_awcache, m0_awprot};
        s_awid     = !aw_fwd ? 4'd0 : wr_gnt ? M1_ID : M0_ID;
        s_awvalid  = aw_fwd && (wr_gnt ? m1_awvalid : m0_awvalid);
        m0_awready = aw_fwd && !wr_gnt && s_awready;
        m1_awready = aw_fwd && wr_gnt && s_awready;
        {s_wdata, s_wstrb, s_wlast} = !w_fwd ? '0 :
            wr_gnt ? {m1_wdata, m1_wstrb, m1_wlast} : {m0_wdata, m0_wstrb, m0_wlast};
        s_wid      = !w_fwd ? 4'd0 : wr_gnt ? M1_ID : M0_ID;
        s_wvalid   = w_fwd && (wr_gnt ? m1_wvalid : m0_wvalid);
        m0_wready  = w_fwd && !wr_gnt && s_wready;
        m1_wready  = w_fwd && wr_gnt && s_wready;
        {m0_bid, m0_bresp} = (b_route && !wr_gnt) ? {s_bid, s_bresp} : '0;
        {m1_bid, m1_bresp} = (b_route && wr_gnt) ? {s_bid, s_bresp} : '0;
        m0_bvalid  = b_route && !wr_gnt && s_bvalid;
        m1_bvalid  = b_route && wr_gnt && s_bvalid;
        s_bready   = b_route && (wr_gnt ? m1_bready : m0_bready);
    end
endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb_axi_master_arbiter: directed bench for the 2:1 AXI3 arbiter with a hand-driven slave.
module tb_axi_master_arbiter;
    logic clk, rst;
    logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [7:0]  m0_arlen, m1_arlen, m0_awlen, m1_awlen;
    logic [2:0]  m0_arsize, m1_arsize, m0_arprot, m1_arprot, m0_awsize, m1_awsize, m0_awprot, m1_awprot;
    logic [1:0]  m0_arburst, m1_arburst, m0_arlock, m1_arlock, m0_awburst, m1_awburst, m0_awlock, m1_awlock;
    logic [3:0]  m0_arcache, m1_arcache, m0_awcache, m1_awcache, m0_arid, m1_arid, m0_awid, m1_awid;
    logic [3:0]  m0_wid, m1_wid, m0_wstrb, m1_wstrb, m0_rid, m1_rid, m0_bid, m1_bid;
    logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
    logic m0_arvalid, m1_arvalid, m0_arready, m1_arready, m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
    logic m0_rready, m1_rready, m0_awvalid, m1_awvalid, m0_awready, m1_awready;
    logic m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
    logic m0_bvalid, m1_bvalid, m0_bready, m1_bready;
    logic [3:0]  s_arid, s_awid, s_wid, s_rid, s_bid, s_arcache, s_awcache, s_wstrb;
    logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
    logic [7:0]  s_arlen, s_awlen;
    logic [2:0]  s_arsize, s_arprot, s_awsize, s_awprot;
    logic [1:0]  s_arburst, s_arlock, s_awburst, s_awlock, s_rresp, s_bresp;
    logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, s_awvalid, s_awready;
    logic s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    int n_tests = 0, n_fail = 0;

    axi_master_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arlock(m0_arlock), .m0_arcache(m0_arcache), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid),
        .m0_arid(m0_arid), .m0_arready(m0_arready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
        .m0_awburst(m0_awburst), .m0_awlock(m0_awlock), .m0_awcache(m0_awcache), .m0_awprot(m0_awprot),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_wid(m0_wid), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arlock(m1_arlock), .m1_arcache(m1_arcache), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid),
        .m1_arid(m1_arid), .m1_arready(m1_arready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
        .m1_awburst(m1_awburst), .m1_awlock(m1_awlock), .m1_awcache(m1_awcache), .m1_awprot(m1_awprot),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_wid(m1_wid), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_wid(s_wid), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ar(input bit m, input logic [31:0] addr, input logic [7:0] len);
        if (m) begin m1_arvalid = 1; m1_araddr = addr; m1_arlen = len; m1_arid = 4'hF; end
        else begin m0_arvalid = 1; m0_araddr = addr; m0_arlen = len; m0_arid = 4'hE; end
        s_arready = 1;
        #1 check("ar_latency", s_arvalid, 0);
        tick();
        check("arvalid", s_arvalid, 1);
        check("arid", s_arid, m ? 4'd1 : 4'd0);
        check("araddr", s_araddr, addr);
        check("arlen", s_arlen, len);
        check("arready_gnt", m ? m1_arready : m0_arready, 1);
        check("arready_other", m ? m0_arready : m1_arready, 0);
        tick();
        if (m) m1_arvalid = 0; else m0_arvalid = 0;
    endtask

    // Slave drives beats base+i; optional 5-cycle rvalid stall and master rready toggling
    task automatic serve_read(input bit m, input int n, input int total, input bit stall, input bit toggle);
        int i = 0;
        int c = 0;
        bit rr;
        while (i < n && c < 200) begin
            s_rvalid = !(stall && c >= 3 && c < 8);
            s_rdata = 32'hD000_0000 + i;
            s_rlast = (i == total - 1);
            s_rresp = 2'b00;
            s_rid = 4'h9;
            rr = toggle ? (c % 3 != 1) : 1'b1;
            if (m) m1_rready = rr; else m0_rready = rr;
            #1;
            check("rvalid", m ? m1_rvalid : m0_rvalid, s_rvalid);
            check("rvalid_other", m ? m0_rvalid : m1_rvalid, 0);
            check("rready", s_rready, rr);
            if (s_rvalid) check("rdata", m ? m1_rdata : m0_rdata, 32'hD000_0000 + i);
            if (s_rvalid && rr) i++;
            c++;
            tick();
        end
        check("rbeats", i, n);
        s_rvalid = 0; s_rlast = 0;
        m0_rready = 0; m1_rready = 0;
    endtask

    task automatic set_w(input bit m, input bit v, input logic [31:0] d, input bit l);
        if (m) begin m1_wvalid = v; m1_wdata = d; m1_wlast = l; m1_wstrb = 4'hF; m1_wid = 4'hC; end
        else begin m0_wvalid = v; m0_wdata = d; m0_wlast = l; m0_wstrb = 4'hF; m0_wid = 4'hC; end
    endtask

    task automatic do_write(input bit m, input logic [31:0] addr, input logic [7:0] len, input int aw_delay);
        int beat = 0;
        int c = 0;
        bit aw_sent = 0;
        bit aw_h, w_h;
        if (m) begin m1_awvalid = 1; m1_awaddr = addr; m1_awlen = len; m1_awid = 4'hB; end
        else begin m0_awvalid = 1; m0_awaddr = addr; m0_awlen = len; m0_awid = 4'hB; end
        s_awready = 0; s_wready = 1; s_bvalid = 0;
        set_w(m, 1, 32'h5000_0000, len == 0);
        tick();
        while ((beat <= int'(len) || !aw_sent) && c < 100) begin
            s_awready = (c >= aw_delay);
            set_w(m, beat <= int'(len), 32'h5000_0000 + beat, beat == int'(len));
            #1;
            check("awvalid", s_awvalid, !aw_sent);
            if (!aw_sent) begin
                check("awid", s_awid, m ? 4'd1 : 4'd0);
                check("awaddr", s_awaddr, addr);
                check("awlen", s_awlen, len);
                check("awready", m ? m1_awready : m0_awready, s_awready);
            end
            check("wvalid", s_wvalid, beat <= int'(len));
            check("wready", m ? m1_wready : m0_wready, beat <= int'(len));
            if (beat <= int'(len)) begin
                check("wdata", s_wdata, 32'h5000_0000 + beat);
                check("wid", s_wid, m ? 4'd1 : 4'd0);
            end
            aw_h = !aw_sent && s_awready;
            w_h = beat <= int'(len);
            c++;
            tick();
            if (aw_h) begin
                aw_sent = 1;
                if (m) m1_awvalid = 0; else m0_awvalid = 0;
            end
            if (w_h) beat++;
        end
        set_w(m, 0, 32'h0, 0);
        check("wr_done", aw_sent && beat == int'(len) + 1, 1);
        s_bvalid = 1; s_bresp = 2'b10; s_bid = 4'h6;
        if (m) m1_bready = 1; else m0_bready = 1;
        #1;
        check("bvalid", m ? m1_bvalid : m0_bvalid, 1);
        check("bvalid_other", m ? m0_bvalid : m1_bvalid, 0);
        check("bresp", m ? m1_bresp : m0_bresp, 2'b10);
        check("bid", m ? m1_bid : m0_bid, 4'h6);
        check("bready", s_bready, 1);
        tick();
        s_bvalid = 0; s_bresp = 0;
        #1 check("wr_idle", s_bready, 0);
        m0_bready = 0; m1_bready = 0;
    endtask

    initial begin
        {m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arlock, m0_arcache, m0_arprot, m0_arvalid, m0_arid} = '0;
        {m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arlock, m1_arcache, m1_arprot, m1_arvalid, m1_arid} = '0;
        {m0_awaddr, m0_awlen, m0_awsize, m0_awburst, m0_awlock, m0_awcache, m0_awprot, m0_awvalid, m0_awid} = '0;
        {m1_awaddr, m1_awlen, m1_awsize, m1_awburst, m1_awlock, m1_awcache, m1_awprot, m1_awvalid, m1_awid} = '0;
        {m0_wid, m0_wdata, m0_wstrb, m0_wlast, m0_wvalid, m0_rready, m0_bready} = '0;
        {m1_wid, m1_wdata, m1_wstrb, m1_wlast, m1_wvalid, m1_rready, m1_bready} = '0;
        {s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, s_awready, s_wready, s_bid, s_bresp, s_bvalid} = '0;
        rst = 0;
        // Requests and slave readiness held during reset must not leak through
        m0_arvalid = 1; m0_araddr = 32'h1234_5678; m1_awvalid = 1; m1_wvalid = 1;
        s_arready = 1; s_wready = 1; s_rvalid = 1; m1_rready = 1;
        repeat (2) tick();
        check("rst_arvalid", s_arvalid, 0);
        check("rst_araddr", s_araddr, 0);
        check("rst_arready", m0_arready, 0);
        check("rst_awvalid", s_awvalid, 0);
        check("rst_wvalid", s_wvalid, 0);
        check("rst_wready", m1_wready, 0);
        check("rst_rvalid", m1_rvalid, 0);
        check("rst_rready", s_rready, 0);
        m0_arvalid = 0; m0_araddr = 0; m1_awvalid = 0; m1_wvalid = 0; s_rvalid = 0; m1_rready = 0;
        rst = 1;
        tick();

        // 1: lone M1 16-beat read
        do_ar(1, 32'h1FC0_0040, 8'd15);
        serve_read(1, 16, 16, 0, 0);
        m1_rready = 1;
        #1 check("t1_rd_idle", s_rready, 0);
        m1_rready = 0;

        // 2: simultaneous requests after reset, M0 first, then alternating
        rst = 0;
        tick();
        rst = 1;
        m0_arvalid = 1; m0_araddr = 32'h0000_1000; m0_arlen = 0;
        m1_arvalid = 1; m1_araddr = 32'h2000_0000; m1_arlen = 0;
        s_arready = 1;
        #1 check("t2_idle", s_arvalid, 0);
        tick();
        check("t2_gnt0_id", s_arid, 4'd0);
        check("t2_gnt0_addr", s_araddr, 32'h0000_1000);
        check("t2_gnt0_rdy", m0_arready, 1);
        check("t2_m1_wait", m1_arready, 0);
        tick();
        m0_arvalid = 0;
        serve_read(0, 1, 1, 0, 0);
        m0_arvalid = 1; m0_araddr = 32'h0000_1040;
        #1 check("t2_idle2", s_arvalid, 0);
        tick();
        check("t2_gnt1_id", s_arid, 4'd1);
        check("t2_gnt1_addr", s_araddr, 32'h2000_0000);
        check("t2_gnt1_rdy", m1_arready, 1);
        check("t2_m0_wait", m0_arready, 0);
        tick();
        m1_arvalid = 0;
        serve_read(1, 1, 1, 0, 0);
        tick();
        check("t2_gnt0b_id", s_arid, 4'd0);
        check("t2_gnt0b_addr", s_araddr, 32'h0000_1040);
        tick();
        m0_arvalid = 0;
        serve_read(0, 1, 1, 0, 0);

        // 3: concurrent M1 read burst and write burst
        fork
            begin
                do_ar(1, 32'h4000_0000, 8'd15);
                serve_read(1, 16, 16, 0, 0);
            end
            do_write(1, 32'h9000_0100, 8'd15, 2);
        join

        // 4: single uncached store, W accepted before AW, early bvalid held off
        m1_awvalid = 1; m1_awaddr = 32'h8000_0002; m1_awlen = 0;
        m1_wvalid = 1; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0100; m1_wlast = 1;
        s_awready = 0; s_wready = 1; s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'h2; m1_bready = 1;
        #1;
        check("t4_w_before_gnt", m1_wready, 0);
        check("t4_wvalid_idle", s_wvalid, 0);
        check("t4_b_idle", m1_bvalid, 0);
        tick();
        check("t4_awvalid", s_awvalid, 1);
        check("t4_awid", s_awid, 4'd1);
        check("t4_wvalid", s_wvalid, 1);
        check("t4_wstrb", s_wstrb, 4'b0100);
        check("t4_wready", m1_wready, 1);
        check("t4_awready", m1_awready, 0);
        check("t4_b_early", m1_bvalid, 0);
        check("t4_bready_early", s_bready, 0);
        tick();
        m1_wvalid = 0;
        #1;
        check("t4_aw_still", s_awvalid, 1);
        check("t4_w_done", s_wvalid, 0);
        check("t4_b_wait", m1_bvalid, 0);
        s_awready = 1; m1_bready = 0;
        #1;
        check("t4_awready", m1_awready, 1);
        check("t4_b_exit", m1_bvalid, 1);
        tick();
        m1_awvalid = 0; s_awready = 0;
        #1;
        check("t4_wrb_bvalid", m1_bvalid, 1);
        check("t4_wrb_other", m0_bvalid, 0);
        check("t4_wrb_bid", m1_bid, 4'h2);
        m1_bready = 1;
        #1 check("t4_bready", s_bready, 1);
        tick();
        s_bvalid = 0;
        #1 check("t4_idle", s_bready, 0);
        m1_bready = 0;

        // 5: slave stall and toggling rready over a 16-beat burst
        do_ar(1, 32'h1FC0_0100, 8'd15);
        serve_read(1, 16, 16, 1, 1);

        // 6: asynchronous reset during beat 7, then a fresh M0 read
        do_ar(1, 32'h1FC0_0200, 8'd15);
        serve_read(1, 7, 16, 0, 0);
        s_rvalid = 1; s_rdata = 32'hD000_0007; s_rlast = 0; m1_rready = 1;
        #1 check("t6_beat7", m1_rvalid, 1);
        rst = 0;
        #1;
        check("t6_rvalid_async", m1_rvalid, 0);
        check("t6_rready_async", s_rready, 0);
        check("t6_rdata_async", m1_rdata, 0);
        tick();
        s_rvalid = 0; m1_rready = 0; rst = 1;
        do_ar(0, 32'h0000_2000, 8'd0);
        serve_read(0, 1, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end
endmodule
